regfile_bypass_sb: RTL and testbench
====================================

# regfile_bypass_sb

Parametrised general-purpose register file for the MIPS CPU datapath. It supersedes the fixed 32×32 register file and adds several features:
- Configurable data width and register count.
- Byte-granular LWL/LWR merge against the destination register's own old value.
- A byte-enable write mode.
- Hardwired zero register.
- Optional write-to-read bypass.
- A per-register load-pending scoreboard for hazard detection by the control unit.

## Interface
Parameters:
- DATA_W, 32, register width in bits; multiple of 8, ≥16
- NREGS, 32, number of registers; power of 2
- ADDR_W, 5, register address width; must equal log2(NREGS)
- BYPASS, 1, 1 = same-cycle write data visible on read ports; 0 = reads show stored value only

Let NB = DATA_W/8 and OW = log2(NB).

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- rd_addr1  in  ADDR_W  read port 1 address
- rd_addr2  in  ADDR_W  read port 2 address
- rd_data1  out  DATA_W  read port 1 data
- rd_data2  out  DATA_W  read port 2 data
- wr_mode  in  3  0 none, 1 full, 2 LWL merge, 3 LWR merge, 4 byte-enable; 5–7 treated as none
- wr_addr  in  ADDR_W  destination register
- wr_data  in  DATA_W  write/load data
- wr_off  in  OW  byte offset (low address bits) for LWL/LWR
- wr_be  in  NB  byte enables for mode 4; bit i covers bits [8i+7:8i]
- lock_en  in  1  mark lock_addr load-pending
- lock_addr  in  ADDR_W  register to lock
- hazard1  out  1  busy[rd_addr1]
- hazard2  out  1  busy[rd_addr2]
- busy_any  out  1  OR of all busy bits
- reg_v0  out  DATA_W  stored value of register 2, no bypass

## Operation
Merged value M is computed from old = stored[wr_addr] and k = wr_off:
- Mode 1: M = wr_data.
- Mode 2 (LWL): the top (k+1) bytes of M are wr_data's low (k+1) bytes; the remaining low bytes come from old. For k = NB−1, M = wr_data.
- Mode 3 (LWR): the low (NB−k) bytes of M are wr_data's low (NB−k) bytes; the remaining top k bytes come from old. For k = 0, M = wr_data.
- Mode 4: byte i of M is wr_data byte i if wr_be[i], else old byte i. wr_be = 0 is a no-op write.

The merge always uses the destination's stored value, never a read port.

Register 0:
- Always reads 0; writes to it are discarded.
- lock_en to register 0 is ignored.

Reads:
- Combinational.
- If BYPASS = 1 and a valid write (modes 1–4, wr_addr ≠ 0) targets the read address in the same cycle, rd_data returns M. Otherwise it returns the stored value.

Scoreboard:
- One busy bit per register.
- A valid write to register r clears busy[r]; lock_en sets busy[lock_addr].
- If both target the same register in one cycle, set wins and busy stays 1.
- Modes 0 and 5–7 do not clear busy.
- hazard outputs reflect the registered busy bits only; no bypass clears them early.

## Timing
- Reset: at the clock edge with reset = 1, all NREGS registers (including the highest index) and all busy bits clear to 0. Writes and locks in that cycle are ignored.
- Outputs from the cycle after reset: rd_data1/2 = 0, reg_v0 = 0, hazard1/2 = 0, busy_any = 0.
- Write latency: the stored value updates at the edge ending the write cycle and appears on non-bypassed reads the following cycle. With BYPASS = 1 the read sees M combinationally in the same cycle.
- Lock latency: hazard asserts the cycle after lock_en and remains asserted until the edge where the matching write occurs. hazard is low in the cycle after that edge.
- Write and lock on different registers in the same cycle update independently.
- Reset asserted mid-load clears busy; the pending write, if later presented, is accepted normally.

## Test plan
- Reset then read all addresses → every rd_data = 0, hazard = 0, busy_any = 0, including register NREGS−1 preloaded with 0xFFFFFFFF before reset.
- Full write 0xDEADBEEF to r5, read r5 in the same cycle with BYPASS = 1 → 0xDEADBEEF. With BYPASS = 0 → old value, then 0xDEADBEEF next cycle.
- r8 = 0x11223344, LWL wr_data = 0xAABBCCDD at off 0/1/2/3 → 0xDD223344 / 0xCCDD3344 / 0xBBCCDD44 / 0xAABBCCDD.
- r8 = 0x11223344, LWR wr_data = 0xAABBCCDD at off 0/1/2/3 → 0xAABBCCDD / 0x11BBCCDD / 0x1122CCDD / 0x112233DD.
- Byte-enable wr_be = 4'b0101, wr_data = 0xAABBCCDD on r9 = 0 → 0x00BB00DD. Full write to r0 → r0 still reads 0.
- Lock r4 → hazard1 high next cycle with rd_addr1 = 4. Write r4 with a simultaneous lock of r4 → stays busy. Write r4 alone → hazard low next cycle, busy_any = 0.

Source files
------------

// File: rtl/regfile_bypass_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_bypass_sb
// Brief    : Parametrised GPR file with LWL/LWR/byte-enable merge, hardwired
//            zero register, optional write-to-read bypass, load scoreboard.
// Revision : 1.0
// ============================================================================
module regfile_bypass_sb #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1,
    localparam int NB    = DATA_W / 8,
    localparam int OW    = $clog2(NB)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic [2:0]        wr_mode,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [OW-1:0]     wr_off,
    input  logic [NB-1:0]     wr_be,
    input  logic              lock_en,
    input  logic [ADDR_W-1:0] lock_addr,
    output logic              hazard1,
    output logic              hazard2,
    output logic              busy_any,
    output logic [DATA_W-1:0] reg_v0
);

    localparam logic [2:0] MODE_FULL = 3'd1;
    localparam logic [2:0] MODE_LWL  = 3'd2;
    localparam logic [2:0] MODE_LWR  = 3'd3;
    localparam logic [2:0] MODE_BE   = 3'd4;

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  busy;

    logic [DATA_W-1:0] old_val;
    logic [DATA_W-1:0] src;
    logic [DATA_W-1:0] merged;
    logic [NB-1:0]     byte_sel;
    logic              write_valid;

    assign write_valid = (wr_mode == MODE_FULL || wr_mode == MODE_LWL ||
                          wr_mode == MODE_LWR  || wr_mode == MODE_BE) &&
                         (wr_addr != '0);

    // Each byte of the merged value comes either from (possibly shifted)
    // wr_data or from the destination's own stored value.
    always_comb begin
        int k;
        k        = int'(wr_off);
        old_val  = regs[wr_addr];
        src      = wr_data;
        byte_sel = '0;
        case (wr_mode)
            MODE_FULL: byte_sel = '1;
            MODE_LWL: begin
                src = wr_data << (8 * (NB - 1 - k));
                for (int i = 0; i < NB; i++) begin
                    byte_sel[i] = (i >= NB - 1 - k);
                end
            end
            MODE_LWR: begin
                for (int i = 0; i < NB; i++) begin
                    byte_sel[i] = (i < NB - k);
                end
            end
            MODE_BE:  byte_sel = wr_be;
            default:  byte_sel = '0;
        endcase
        for (int i = 0; i < NB; i++) begin
            merged[8*i +: 8] = byte_sel[i] ? src[8*i +: 8] : old_val[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (write_valid) begin
                regs[wr_addr] <= merged;
                busy[wr_addr] <= 1'b0;
            end
            // Issued after the clear so a same-register lock wins.
            if (lock_en && lock_addr != '0) begin
                busy[lock_addr] <= 1'b1;
            end
        end
    end

    always_comb begin
        if (rd_addr1 == '0) begin
            rd_data1 = '0;
        end else if (BYPASS != 0 && write_valid && wr_addr == rd_addr1) begin
            rd_data1 = merged;
        end else begin
            rd_data1 = regs[rd_addr1];
        end

        if (rd_addr2 == '0) begin
            rd_data2 = '0;
        end else if (BYPASS != 0 && write_valid && wr_addr == rd_addr2) begin
            rd_data2 = merged;
        end else begin
            rd_data2 = regs[rd_addr2];
        end
    end

    assign hazard1  = busy[rd_addr1];
    assign hazard2  = busy[rd_addr2];
    assign busy_any = |busy;
    assign reg_v0   = regs[2];

endmodule
`default_nettype wire

// File: tb/tb_regfile_bypass_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_bypass_sb
// Brief    : Directed self-checking bench for regfile_bypass_sb (BYPASS 1 and 0).
// Revision : 1.0
// ============================================================================
module tb_regfile_bypass_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rd_addr1, rd_addr2, wr_addr, lock_addr;
    logic [2:0]  wr_mode;
    logic [31:0] wr_data;
    logic [1:0]  wr_off;
    logic [3:0]  wr_be;
    logic        lock_en;

    logic [31:0] rd1_b, rd2_b, v0_b, rd1_n, rd2_n, v0_n;
    logic        hz1_b, hz2_b, any_b, hz1_n, hz2_n, any_n;

    int errors = 0;
    int checks = 0;

    logic [31:0] lwl_exp [4] = '{32'hDD223344, 32'hCCDD3344, 32'hBBCCDD44, 32'hAABBCCDD};
    logic [31:0] lwr_exp [4] = '{32'hAABBCCDD, 32'h11BBCCDD, 32'h1122CCDD, 32'h112233DD};

    always #5 clk = ~clk;

    regfile_bypass_sb #(.DATA_W(32), .NREGS(32), .ADDR_W(5), .BYPASS(1)) dut (
        .clk(clk), .reset(reset),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd1_b), .rd_data2(rd2_b),
        .wr_mode(wr_mode), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_off(wr_off), .wr_be(wr_be),
        .lock_en(lock_en), .lock_addr(lock_addr),
        .hazard1(hz1_b), .hazard2(hz2_b), .busy_any(any_b), .reg_v0(v0_b)
    );

    regfile_bypass_sb #(.DATA_W(32), .NREGS(32), .ADDR_W(5), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd1_n), .rd_data2(rd2_n),
        .wr_mode(wr_mode), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_off(wr_off), .wr_be(wr_be),
        .lock_en(lock_en), .lock_addr(lock_addr),
        .hazard1(hz1_n), .hazard2(hz2_n), .busy_any(any_n), .reg_v0(v0_n)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] m, input logic [4:0] a, input logic [31:0] d,
                      input logic [1:0] off, input logic [3:0] be);
        wr_mode = m;
        wr_addr = a;
        wr_data = d;
        wr_off  = off;
        wr_be   = be;
    endtask

    task automatic lock(input logic en, input logic [4:0] a);
        lock_en   = en;
        lock_addr = a;
    endtask

    initial begin
        reset = 1'b1;
        rd_addr1 = '0; rd_addr2 = '0;
        wr(3'd0, 5'd0, 32'h0, 2'd0, 4'h0);
        lock(1'b0, 5'd0);
        tick();
        reset = 1'b0;

        // Preload top register and a lock, then reset with a write/lock pending
        wr(3'd1, 5'd31, 32'hFFFFFFFF, 2'd0, 4'h0);
        lock(1'b1, 5'd7);
        tick();
        wr(3'd0, 5'd0, 32'h0, 2'd0, 4'h0);
        lock(1'b0, 5'd0);
        rd_addr1 = 5'd31;
        #1;
        chk("preload_r31", rd1_n, 32'hFFFFFFFF);
        chk("preload_busy", {31'b0, any_b}, 32'd1);

        reset = 1'b1;
        wr(3'd1, 5'd5, 32'h00001234, 2'd0, 4'h0);
        lock(1'b1, 5'd6);
        tick();
        reset = 1'b0;
        wr(3'd0, 5'd0, 32'h0, 2'd0, 4'h0);
        lock(1'b0, 5'd0);
        for (int a = 0; a < 32; a++) begin
            rd_addr1 = 5'(a);
            rd_addr2 = 5'(31 - a);
            #1;
            chk($sformatf("rst_rd1_b[%0d]", a), rd1_b, 32'h0);
            chk($sformatf("rst_hz1_b[%0d]", a), {31'b0, hz1_b}, 32'h0);
            chk($sformatf("rst_rd2_n[%0d]", 31 - a), rd2_n, 32'h0);
        end
        chk("rst_busy_any", {31'b0, any_b}, 32'h0);
        chk("rst_reg_v0", v0_b, 32'h0);

        // Full write with and without bypass
        wr(3'd1, 5'd5, 32'h12345678, 2'd0, 4'h0);
        tick();
        wr(3'd1, 5'd5, 32'hDEADBEEF, 2'd0, 4'h0);
        rd_addr1 = 5'd5;
        #1;
        chk("byp_same_cycle", rd1_b, 32'hDEADBEEF);
        chk("nobyp_same_cycle", rd1_n, 32'h12345678);
        tick();
        wr(3'd0, 5'd0, 32'h0, 2'd0, 4'h0);
        #1;
        chk("nobyp_next_cycle", rd1_n, 32'hDEADBEEF);
        chk("byp_next_cycle", rd1_b, 32'hDEADBEEF);

        // LWL and LWR merges against r8 = 0x11223344
        rd_addr2 = 5'd8;
        for (int k = 0; k < 4; k++) begin
            wr(3'd1, 5'd8, 32'h11223344, 2'd0, 4'h0);
            tick();
            wr(3'd2, 5'd8, 32'hAABBCCDD, 2'(k), 4'h0);
            #1;
            chk($sformatf("lwl_byp[%0d]", k), rd2_b, lwl_exp[k]);
            tick();
            wr(3'd0, 5'd0, 32'h0, 2'd0, 4'h0);
            #1;
            chk($sformatf("lwl_stored[%0d]", k), rd2_n, lwl_exp[k]);
        end
        for (int k = 0; k < 4; k++) begin
            wr(3'd1, 5'd8, 32'h11223344, 2'd0, 4'h0);
            tick();
            wr(3'd3, 5'd8, 32'hAABBCCDD, 2'(k), 4'h0);
            #1;
            chk($sformatf("lwr_byp[%0d]", k), rd2_b, lwr_exp[k]);
            tick();
            wr(3'd0, 5'd0, 32'h0, 2'd0, 4'h0);
            #1;
            chk($sformatf("lwr_stored[%0d]", k), rd2_n, lwr_exp[k]);
        end

        // Byte-enable write, empty byte mask, zero register
        rd_addr1 = 5'd9;
        wr(3'd4, 5'd9, 32'hAABBCCDD, 2'd0, 4'b0101);
        tick();
        wr(3'd4, 5'd9, 32'hFFFFFFFF, 2'd0, 4'b0000);
        #1;
        chk("be_0101", rd1_n, 32'h00BB00DD);
        chk("be_none_byp", rd1_b, 32'h00BB00DD);
        tick();
        wr(3'd1, 5'd0, 32'hDEADBEEF, 2'd0, 4'h0);
        rd_addr2 = 5'd0;
        #1;
        chk("be_none_stored", rd1_n, 32'h00BB00DD);
        chk("r0_byp", rd2_b, 32'h0);
        tick();
        wr(3'd5, 5'd9, 32'h55555555, 2'd0, 4'hF);
        #1;
        chk("r0_stored", rd2_n, 32'h0);
        tick();
        wr(3'd0, 5'd0, 32'h0, 2'd0, 4'h0);
        #1;
        chk("mode5_nowrite", rd1_n, 32'h00BB00DD);

        // reg_v0 tracks the stored value of r2 only
        wr(3'd1, 5'd2, 32'hCAFEF00D, 2'd0, 4'h0);
        #1;
        chk("v0_no_bypass", v0_b, 32'h0);
        tick();
        wr(3'd0, 5'd0, 32'h0, 2'd0, 4'h0);
        #1;
        chk("v0_written", v0_b, 32'hCAFEF00D);

        // Scoreboard
        rd_addr1 = 5'd4;
        rd_addr2 = 5'd7;
        lock(1'b1, 5'd4);
        #1;
        chk("lock_not_yet", {31'b0, hz1_b}, 32'h0);
        tick();
        lock(1'b0, 5'd0);
        #1;
        chk("lock_hz1", {31'b0, hz1_b}, 32'h1);
        chk("lock_busy_any", {31'b0, any_b}, 32'h1);
        wr(3'd1, 5'd4, 32'h00000044, 2'd0, 4'h0);
        lock(1'b1, 5'd4);
        tick();
        lock(1'b0, 5'd0);
        #1;
        chk("set_wins", {31'b0, hz1_b}, 32'h1);
        chk("write_with_lock_data", rd1_n, 32'h00000044);
        wr(3'd1, 5'd4, 32'h00000444, 2'd0, 4'h0);
        #1;
        chk("hz_held_during_write", {31'b0, hz1_b}, 32'h1);
        tick();
        wr(3'd0, 5'd0, 32'h0, 2'd0, 4'h0);
        #1;
        chk("hz_cleared", {31'b0, hz1_b}, 32'h0);
        chk("busy_any_cleared", {31'b0, any_n}, 32'h0);

        lock(1'b1, 5'd0);
        tick();
        lock(1'b0, 5'd0);
        #1;
        chk("lock_r0_ignored", {31'b0, any_b}, 32'h0);

        // Write and lock on different registers in one cycle
        wr(3'd1, 5'd6, 32'h66666666, 2'd0, 4'h0);
        lock(1'b1, 5'd7);
        rd_addr1 = 5'd6;
        tick();
        wr(3'd0, 5'd0, 32'h0, 2'd0, 4'h0);
        lock(1'b0, 5'd0);
        #1;
        chk("indep_lock_hz2", {31'b0, hz2_b}, 32'h1);
        chk("indep_lock_hz1", {31'b0, hz1_b}, 32'h0);
        chk("indep_write", rd1_n, 32'h66666666);

        wr(3'd6, 5'd7, 32'h77777777, 2'd0, 4'h0);
        tick();
        wr(3'd0, 5'd0, 32'h0, 2'd0, 4'h0);
        #1;
        chk("mode6_no_clear", {31'b0, hz2_n}, 32'h1);

        // Reset mid-load, then the pending write lands normally
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("reset_mid_load", {31'b0, any_b}, 32'h0);
        wr(3'd1, 5'd7, 32'h0000BEEF, 2'd0, 4'h0);
        tick();
        wr(3'd0, 5'd0, 32'h0, 2'd0, 4'h0);
        rd_addr1 = 5'd7;
        #1;
        chk("post_reset_write", rd1_n, 32'h0000BEEF);
        chk("post_reset_hz", {31'b0, hz1_b}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
